// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush/forwarding sequencer for the 5-stage RV32I pipeline
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [4:0]       i_id_rs1_addr,
    input  logic [4:0]       i_id_rs2_addr,
    input  logic             i_id_rs1_used,
    input  logic             i_id_rs2_used,
    input  logic [4:0]       i_ex_rd_addr,
    input  logic             i_ex_rd_wren,
    input  logic             i_ex_is_load,
    input  logic [4:0]       i_mem_rd_addr,
    input  logic             i_mem_rd_wren,
    input  logic [4:0]       i_wb_rd_addr,
    input  logic             i_wb_rd_wren,
    input  logic [4:0]       i_ex_rs1_addr,
    input  logic [4:0]       i_ex_rs2_addr,
    input  logic             i_ex_mispred,
    input  logic             i_mem_req,
    input  logic             i_mem_ack,
    output logic             o_stall_if,
    output logic             o_stall_id,
    output logic             o_stall_ex,
    output logic             o_stall_mem,
    output logic             o_flush_id,
    output logic             o_flush_ex,
    output logic             o_flush_wb,
    output logic [1:0]       o_fwd_a,
    output logic [1:0]       o_fwd_b,
    output logic             o_mem_err,
    output logic [CNT_W-1:0] o_cnt_lu_stall,
    output logic [CNT_W-1:0] o_cnt_mem_wait
);

    typedef enum logic {ST_RUN, ST_WAIT} state_t;

    localparam logic [15:0] WCNT_LAST = 16'(MEM_TIMEOUT - 1);

    state_t           r_state, w_state_nxt;
    logic [15:0]      r_wcnt, w_wcnt_nxt;
    logic             r_mem_err;
    logic [CNT_W-1:0] r_cnt_lu, r_cnt_mw;
    logic             w_timeout, w_mw, w_lu, w_lu_act;

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                           input logic [4:0] mem_rd, input logic mem_wren,
                                           input logic [4:0] wb_rd,  input logic wb_wren);
        if (mem_wren && mem_rd != 5'd0 && mem_rd == rs)
            return 2'b01;
        else if (wb_wren && wb_rd != 5'd0 && wb_rd == rs)
            return 2'b10;
        else
            return 2'b00;
    endfunction

    always_comb begin
        w_state_nxt = r_state;
        w_wcnt_nxt  = r_wcnt;
        w_timeout   = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (i_mem_req && !i_mem_ack) begin
                    w_state_nxt = ST_WAIT;
                    w_wcnt_nxt  = 16'd0;
                end
            end
            ST_WAIT: begin
                if (i_mem_ack) begin
                    w_state_nxt = ST_RUN;
                end else if (r_wcnt == WCNT_LAST) begin
                    w_state_nxt = ST_RUN;
                    w_timeout   = 1'b1;
                end else begin
                    w_wcnt_nxt = r_wcnt + 16'd1;
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    // The abort cycle itself is not a wait: the pipeline advances past the dead access.
    assign w_mw = ((r_state == ST_RUN)  && i_mem_req && !i_mem_ack) ||
                  ((r_state == ST_WAIT) && !i_mem_ack && r_wcnt != WCNT_LAST);

    assign w_lu = i_ex_is_load && i_ex_rd_wren && (i_ex_rd_addr != 5'd0) &&
                  ((i_id_rs1_used && i_id_rs1_addr == i_ex_rd_addr) ||
                   (i_id_rs2_used && i_id_rs2_addr == i_ex_rd_addr));

    assign w_lu_act = w_lu && !w_mw && !i_ex_mispred && !i_reset;

    always_comb begin
        o_stall_if  = 1'b0;
        o_stall_id  = 1'b0;
        o_stall_ex  = 1'b0;
        o_stall_mem = 1'b0;
        o_flush_id  = 1'b0;
        o_flush_ex  = 1'b0;
        o_flush_wb  = 1'b0;
        o_fwd_a     = 2'b00;
        o_fwd_b     = 2'b00;
        if (i_reset) begin
            o_flush_id = 1'b1;
            o_flush_ex = 1'b1;
            o_flush_wb = 1'b1;
        end else begin
            o_fwd_a = fwd_sel(i_ex_rs1_addr, i_mem_rd_addr, i_mem_rd_wren, i_wb_rd_addr, i_wb_rd_wren);
            o_fwd_b = fwd_sel(i_ex_rs2_addr, i_mem_rd_addr, i_mem_rd_wren, i_wb_rd_addr, i_wb_rd_wren);
            if (w_mw) begin
                o_stall_if  = 1'b1;
                o_stall_id  = 1'b1;
                o_stall_ex  = 1'b1;
                o_stall_mem = 1'b1;
                o_flush_wb  = 1'b1;
            end else if (i_ex_mispred) begin
                o_flush_id = 1'b1;
                o_flush_ex = 1'b1;
            end else if (w_lu) begin
                o_stall_if = 1'b1;
                o_stall_id = 1'b1;
                o_flush_ex = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= ST_RUN;
            r_wcnt    <= 16'd0;
            r_mem_err <= 1'b0;
            r_cnt_lu  <= '0;
            r_cnt_mw  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_wcnt    <= w_wcnt_nxt;
            r_mem_err <= w_timeout;
            if (w_lu_act && r_cnt_lu != {CNT_W{1'b1}})
                r_cnt_lu <= r_cnt_lu + CNT_W'(1);
            if (w_mw && r_cnt_mw != {CNT_W{1'b1}})
                r_cnt_mw <= r_cnt_mw + CNT_W'(1);
        end
    end

    assign o_mem_err      = r_mem_err;
    assign o_cnt_lu_stall = r_cnt_lu;
    assign o_cnt_mem_wait = r_cnt_mw;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

    localparam int TO    = 4;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst;
    logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd, wb_rd, ex_rs1, ex_rs2;
    logic id_u1, id_u2, ex_wren, ex_load, mem_wren, wb_wren, mispred, req, ack;
    logic s_if, s_id, s_ex, s_mem, f_id, f_ex, f_wb, mem_err;
    logic [1:0] fwd_a, fwd_b;
    logic [CW-1:0] cnt_lu, cnt_mw;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .i_clk(clk), .i_reset(rst),
        .i_id_rs1_addr(id_rs1), .i_id_rs2_addr(id_rs2),
        .i_id_rs1_used(id_u1), .i_id_rs2_used(id_u2),
        .i_ex_rd_addr(ex_rd), .i_ex_rd_wren(ex_wren), .i_ex_is_load(ex_load),
        .i_mem_rd_addr(mem_rd), .i_mem_rd_wren(mem_wren),
        .i_wb_rd_addr(wb_rd), .i_wb_rd_wren(wb_wren),
        .i_ex_rs1_addr(ex_rs1), .i_ex_rs2_addr(ex_rs2),
        .i_ex_mispred(mispred), .i_mem_req(req), .i_mem_ack(ack),
        .o_stall_if(s_if), .o_stall_id(s_id), .o_stall_ex(s_ex), .o_stall_mem(s_mem),
        .o_flush_id(f_id), .o_flush_ex(f_ex), .o_flush_wb(f_wb),
        .o_fwd_a(fwd_a), .o_fwd_b(fwd_b), .o_mem_err(mem_err),
        .o_cnt_lu_stall(cnt_lu), .o_cnt_mem_wait(cnt_mw)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rs1, rs2; logic u1, u2;
        logic [4:0] exrd; logic exw, exl;
        logic [4:0] memrd; logic memw;
        logic [4:0] wbrd; logic wbw;
        logic [4:0] exrs1, exrs2; logic misp;
        logic [3:0] stall; logic [2:0] flush; logic [1:0] fa, fb;
    } vec_t;

    vec_t vecs[12];
    vec_t cur;
    bit   use_tbl;

    int n_checks = 0;
    int n_errors = 0;

    // reference state: an access in progress and how many cycles it has already stalled
    bit m_in_access;
    int m_k;
    bit m_err, m_mw, m_lu_act, m_to;
    int m_cnt_lu, m_cnt_mw;

    logic [3:0] exp_stall;
    logic [2:0] exp_flush;
    logic [1:0] exp_fa, exp_fb;
    logic       last_stall, last_err;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
        if (mem_wren && mem_rd != 0 && mem_rd == rs) return 2'b01;
        if (wb_wren && wb_rd != 0 && wb_rd == rs) return 2'b10;
        return 2'b00;
    endfunction

    task automatic model_comb();
        bit lu;
        m_mw = 0; m_lu_act = 0; m_to = 0;
        if (rst) begin
            exp_stall = 4'b0000; exp_flush = 3'b111; exp_fa = 2'b00; exp_fb = 2'b00;
        end else begin
            exp_fa = ref_fwd(ex_rs1);
            exp_fb = ref_fwd(ex_rs2);
            m_mw = !ack && (m_in_access ? (m_k < TO) : req);
            m_to = m_in_access && !ack && (m_k == TO);
            lu = ex_load && ex_wren && ex_rd != 0 &&
                 ((id_u1 && id_rs1 == ex_rd) || (id_u2 && id_rs2 == ex_rd));
            if (m_mw) begin
                exp_stall = 4'b1111; exp_flush = 3'b001;
            end else if (mispred) begin
                exp_stall = 4'b0000; exp_flush = 3'b110;
            end else if (lu) begin
                exp_stall = 4'b1100; exp_flush = 3'b010; m_lu_act = 1;
            end else begin
                exp_stall = 4'b0000; exp_flush = 3'b000;
            end
        end
    endtask

    task automatic model_seq();
        if (rst) begin
            m_in_access = 0; m_k = 0; m_err = 0; m_cnt_lu = 0; m_cnt_mw = 0;
        end else begin
            m_err = m_to;
            if (m_mw) begin m_in_access = 1; m_k++; end
            else begin m_in_access = 0; m_k = 0; end
            if (m_lu_act && m_cnt_lu < CMAX) m_cnt_lu++;
            if (m_mw && m_cnt_mw < CMAX) m_cnt_mw++;
        end
    endtask

    // inputs are set by the caller just after a rising edge; outputs sampled mid-cycle
    task automatic do_cycle();
        #4;
        model_comb();
        if (use_tbl) begin
            exp_stall = cur.stall; exp_flush = cur.flush; exp_fa = cur.fa; exp_fb = cur.fb;
        end
        last_stall = s_if;
        chk("stalls", {s_if, s_id, s_ex, s_mem}, exp_stall);
        chk("flushes", {f_id, f_ex, f_wb}, exp_flush);
        chk("fwd_a", fwd_a, exp_fa);
        chk("fwd_b", fwd_b, exp_fb);
        @(posedge clk); #1;
        model_seq();
        last_err = mem_err;
        chk("mem_err", mem_err, m_err);
        chk("cnt_lu_stall", cnt_lu, m_cnt_lu);
        chk("cnt_mem_wait", cnt_mw, m_cnt_mw);
    endtask

    task automatic set_idle();
        id_rs1 = 0; id_rs2 = 0; id_u1 = 0; id_u2 = 0;
        ex_rd = 0; ex_wren = 0; ex_load = 0;
        mem_rd = 0; mem_wren = 0; wb_rd = 0; wb_wren = 0;
        ex_rs1 = 0; ex_rs2 = 0; mispred = 0; req = 0; ack = 0; rst = 0;
    endtask

    task automatic apply_vec(input vec_t v);
        id_rs1 = v.rs1; id_rs2 = v.rs2; id_u1 = v.u1; id_u2 = v.u2;
        ex_rd = v.exrd; ex_wren = v.exw; ex_load = v.exl;
        mem_rd = v.memrd; mem_wren = v.memw; wb_rd = v.wbrd; wb_wren = v.wbw;
        ex_rs1 = v.exrs1; ex_rs2 = v.exrs2; mispred = v.misp;
        req = 0; ack = 0; rst = 0;
    endtask

    task automatic do_reset();
        set_idle(); rst = 1; do_cycle(); rst = 0;
    endtask

    int stall_cnt, err_cnt;

    initial begin
        //          rs1   rs2   u1    u2    exrd  exw   exl   memrd memw  wbrd  wbw   exrs1 exrs2 misp  stall    flush   fa     fb
        vecs[0]  = '{5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 5'd4, 1'b1, 5'd6, 1'b1, 5'd8, 5'd9, 1'b0, 4'b0000, 3'b000, 2'b00, 2'b00};
        vecs[1]  = '{5'd5, 5'd1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 5'd1, 1'b0, 4'b1100, 3'b010, 2'b00, 2'b00};
        vecs[2]  = '{5'd1, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 4'b1100, 3'b010, 2'b00, 2'b00};
        vecs[3]  = '{5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 4'b0000, 3'b000, 2'b00, 2'b00};
        vecs[4]  = '{5'd3, 5'd5, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 4'b0000, 3'b000, 2'b00, 2'b00};
        vecs[5]  = '{5'd5, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 4'b0000, 3'b000, 2'b00, 2'b00};
        vecs[6]  = '{5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 5'd7, 1'b1, 5'd3, 5'd7, 1'b0, 4'b0000, 3'b000, 2'b00, 2'b01};
        vecs[7]  = '{5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd7, 1'b0, 5'd7, 1'b1, 5'd3, 5'd7, 1'b0, 4'b0000, 3'b000, 2'b00, 2'b10};
        vecs[8]  = '{5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 5'd0, 1'b0, 4'b0000, 3'b000, 2'b00, 2'b00};
        vecs[9]  = '{5'd5, 5'd1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b1, 4'b0000, 3'b110, 2'b00, 2'b00};
        vecs[10] = '{5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 5'd3, 1'b1, 5'd3, 5'd2, 1'b1, 4'b0000, 3'b110, 2'b01, 2'b00};
        vecs[11] = '{5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd4, 1'b0, 5'd4, 1'b1, 5'd4, 5'd4, 1'b0, 4'b0000, 3'b000, 2'b10, 2'b10};

        set_idle();
        use_tbl = 0;
        m_in_access = 0; m_k = 0; m_err = 0; m_cnt_lu = 0; m_cnt_mw = 0;
        @(posedge clk); #1;
        do_reset();

        use_tbl = 1;
        for (int i = 0; i < 12; i++) begin
            cur = vecs[i];
            apply_vec(vecs[i]);
            do_cycle();
        end
        use_tbl = 0;

        // load-use: stall once, bubble, then WB forwarding to the consumer
        do_reset();
        set_idle(); ex_load = 1; ex_wren = 1; ex_rd = 5; id_rs1 = 5; id_u1 = 1; id_rs2 = 1; id_u2 = 1;
        do_cycle();
        chk("lu_stall_seen", last_stall, 1);
        set_idle(); mem_rd = 5; mem_wren = 1; id_rs1 = 5; id_u1 = 1;
        do_cycle();
        chk("lu_released", last_stall, 0);
        set_idle(); wb_rd = 5; wb_wren = 1; ex_rs1 = 5;
        do_cycle();
        chk("lu_fwd_a_wb", fwd_a, 2'b10);
        chk("lu_count_one", cnt_lu, 1);

        // ack three cycles after the request
        do_reset();
        stall_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            set_idle(); req = 1; ack = (i == 3);
            do_cycle();
            stall_cnt += int'(last_stall);
        end
        chk("ack3_stall_cycles", stall_cnt, 3);
        chk("ack3_mem_wait_cnt", cnt_mw, 3);
        set_idle(); req = 1; ack = 1;
        do_cycle();
        chk("ack0_no_stall", last_stall, 0);
        chk("ack0_cnt_unchanged", cnt_mw, 3);

        // timeout with no ack
        do_reset();
        stall_cnt = 0; err_cnt = 0;
        for (int i = 0; i < 7; i++) begin
            set_idle(); req = (i < 5);
            do_cycle();
            stall_cnt += int'(last_stall);
            err_cnt   += int'(last_err);
        end
        chk("timeout_stall_cycles", stall_cnt, TO);
        chk("timeout_err_pulses", err_cnt, 1);

        // mispredict held through a memory wait
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_idle(); req = 1; mispred = 1;
            do_cycle();
            chk("misp_wait_no_flush", {f_id, f_ex}, 2'b00);
        end
        set_idle(); req = 1; ack = 1; mispred = 1;
        #4;
        chk("misp_release_flush", {f_id, f_ex, s_if}, 3'b110);
        @(posedge clk); #1;
        m_cnt_mw = 3; m_in_access = 0; m_k = 0; m_err = 0;
        chk("misp_lu_cnt_zero", cnt_lu, 0);

        // reset while waiting drops the access silently
        do_reset();
        for (int i = 0; i < 2; i++) begin
            set_idle(); req = 1;
            do_cycle();
        end
        set_idle(); req = 1; rst = 1;
        do_cycle();
        set_idle();
        do_cycle();
        chk("rst_wait_no_stall", last_stall, 0);
        chk("rst_wait_no_err", last_err, 0);
        chk("rst_wait_cnt_clear", cnt_mw, 0);

        // randomized run against the reference model
        for (int i = 0; i < 3000; i++) begin
            id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
            id_u1 = 1'($urandom); id_u2 = 1'($urandom);
            ex_rd = 5'($urandom_range(0, 3)); ex_wren = 1'($urandom); ex_load = 1'($urandom);
            mem_rd = 5'($urandom_range(0, 3)); mem_wren = 1'($urandom);
            wb_rd = 5'($urandom_range(0, 3)); wb_wren = 1'($urandom);
            ex_rs1 = 5'($urandom_range(0, 3)); ex_rs2 = 5'($urandom_range(0, 3));
            mispred = ($urandom_range(0, 7) == 0);
            req = ($urandom_range(0, 2) == 0);
            ack = ($urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 99) == 0);
            do_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
